goomba_walker: RTL and testbench
================================

# goomba_walker

Autonomous walker actor for Goomba-class enemies. Each frame it moves the sprite along the current surface, reverses at screen edges, and falls under gravity when no surface is beneath it. It snaps onto platforms even when the fall step skips past the exact surface row, and runs a squash/death sequence. It sits between the frame-tick generator and the sprite renderer / Mario collision logic. It replaces single-row ground equality checks with a parametrised platform table and a registered motion state machine.

## Interface
- `WIDTH`, 26: sprite width in pixels (right edge = x+WIDTH).
- `HEIGHT`, 27: sprite height in pixels (bottom = y+HEIGHT).
- `SCREEN_W`, 640: screen width; the rightmost legal right edge is SCREEN_W-1.
- `FLOOR_Y`, 440: floor row; full screen width, always solid.
- `NUM_PLAT`, 9: number of platform entries.
- `PLAT_TABLE`, default below: NUM_PLAT×30 bits. Entry i is at [30i+29:30i] as {left[9:0], right[9:0], top[9:0]}. Default entries 0..8:
  - (10,80,62), (560,630,62)
  - (0,279,138), (360,639,138)
  - (0,79,257), (140,500,240), (560,639,257)
  - (0,218,343), (421,639,343)
- `START_X`, 300; `START_Y`, 0; `START_DIR`, 1: spawn position and direction.
- `WALK_STEP`, 1: pixels moved per frame while walking.
- `FALL_MAX`, 4: terminal fall speed in pixels per frame.
- `SQUASH_FRAMES`, 30: frames spent in DYING.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per video frame; advances motion.
- `enable` in 1: when 0, motion ticks are ignored.
- `kill` in 1: stomp event, one-cycle pulse.
- `spawn` in 1: respawn request, one-cycle pulse.
- `goomba_x` out 10: registered left edge.
- `goomba_y` out 10: registered top edge.
- `dir` out 1: 1 = moving right, 0 = moving left.
- `state` out 2: 0 IDLE, 1 WALK, 2 FALL, 3 DYING.
- `grounded` out 1: combinational; a surface is under the current registered position.
- `alive` out 1: 1 in WALK/FALL only (collision-active).
- `squash` out 1: 1 in DYING (selects squashed sprite).

## Operation
- All geometry arithmetic is 11-bit unsigned, so x+WIDTH and bottom+speed cannot wrap. Outputs are the low 10 bits of registers that never exceed 639/479.
- Overlap with entry i: (x+WIDTH ≥ left_i) && (right_i ≥ x), both inclusive.
- `grounded` = (bottom == FLOOR_Y) OR any overlapping entry with top_i == bottom.
- Event priority at each clk edge: rst_n=0 > spawn > kill > (frame_tick && enable). Otherwise all state holds.
- spawn, from any state: x=START_X, y=START_Y, dir=START_DIR, vy=0, squash counter=0, state=FALL.
- kill: in WALK/FALL goes to DYING with the counter cleared and position frozen. Ignored in IDLE/DYING.
- WALK tick:
  - If not grounded: state=FALL, vy=0, no movement.
  - Else, moving right with x+WIDTH+WALK_STEP > SCREEN_W-1: dir=0, x held.
  - Else, moving left with x < WALK_STEP: dir=1, x held.
  - Otherwise x ± WALK_STEP.
- FALL tick:
  - If grounded: state=WALK, vy=0, no movement.
  - Otherwise v = min(vy+1, FALL_MAX) and nb = bottom+v.
  - Candidate surfaces: overlapping entries, plus the floor, with bottom < top ≤ nb.
  - If any candidate exists, snap y = (smallest candidate top) − HEIGHT, vy=0, state=WALK.
  - Else y += v, vy = v.
  - x does not change in FALL.
- DYING tick: counter++. When counter reaches SQUASH_FRAMES−1 on a tick, state=IDLE. Position is frozen.
- IDLE: ticks ignored; only spawn leaves IDLE.

## Timing
- Reset values: goomba_x=START_X, goomba_y=START_Y, dir=START_DIR, state=FALL, vy=0, counter=0, alive=1, squash=0.
- Position, dir and state update on the same edge that samples the event. Registered outputs therefore change 1 cycle after the event.
- `grounded` has zero latency relative to the registered position.
- kill and spawn act without needing frame_tick.
- Reset mid-fall or mid-DYING returns to the reset values on the next edge.
- Simultaneous spawn+kill: spawn wins.
- Simultaneous kill+tick: kill wins and no motion occurs.

## Test plan
- Spawn fall (defaults): reset, then 55 ticks. The fall step ramps 1,2,3,4,4,… and the 55th tick snaps: y=213 (bottom 240 on mid bar), state=WALK, grounded=1, x=300 throughout.
- Right edge (START_X=610, START_Y=413):
  - Ticks 1..4 give state WALK, then x 611, 612, 613.
  - Tick 5 gives dir=0, x=613; tick 6 gives x=612.
- Ledge walk-off (START_X=50, START_Y=230, dir=1):
  - Walk to x=80 (not grounded, since 80 > 79).
  - The next tick enters FALL.
  - The fall ends snapped at y=316 (top 343) with x=80.
- Kill sequence: in WALK, pulse kill.
  - Next cycle: state=DYING, alive=0, squash=1.
  - After 30 ticks: state=IDLE, squash=0. Further ticks change nothing.
  - Spawn: state=FALL, x=START_X, y=START_Y.
- Priority:
  - spawn+kill in the same cycle gives FALL at the start position.
  - enable=0 with 10 ticks holds every output.
  - rst_n=0 during DYING restores the reset values.

Source files
------------

// File: rtl/goomba_walker.sv
// goomba_walker: per-frame walker actor for Goomba enemies.
// Walks surfaces, turns at edges, falls with snap-to-platform, squashes.
module goomba_walker #(
  parameter int WIDTH         = 26,
  parameter int HEIGHT        = 27,
  parameter int SCREEN_W      = 640,
  parameter int FLOOR_Y       = 440,
  parameter int NUM_PLAT      = 9,
  parameter logic [NUM_PLAT*30-1:0] PLAT_TABLE = {
    {10'd421, 10'd639, 10'd343},
    {10'd0,   10'd218, 10'd343},
    {10'd560, 10'd639, 10'd257},
    {10'd140, 10'd500, 10'd240},
    {10'd0,   10'd79,  10'd257},
    {10'd360, 10'd639, 10'd138},
    {10'd0,   10'd279, 10'd138},
    {10'd560, 10'd630, 10'd62},
    {10'd10,  10'd80,  10'd62}
  },
  parameter int START_X       = 300,
  parameter int START_Y       = 0,
  parameter int START_DIR     = 1,
  parameter int WALK_STEP     = 1,
  parameter int FALL_MAX      = 4,
  parameter int SQUASH_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       kill,
  input  logic       spawn,
  output logic [9:0] goomba_x,
  output logic [9:0] goomba_y,
  output logic       dir,
  output logic [1:0] state,
  output logic       grounded,
  output logic       alive,
  output logic       squash
);

  localparam int CW = $clog2(SQUASH_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FALL  = 2'd2,
    DYING = 2'd3
  } st_t;

  st_t           st_q, st_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          dir_q, dir_d;
  logic [10:0]   vy_q, vy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [10:0]   xl, xe, bot, v, nb;
  logic [10:0]   snap_top, snap_y, fall_y;
  logic          hit;
  logic          gnd;

  // Surface geometry: grounding and smallest landing surface this step.
  always_comb begin
    logic [10:0] lft, rgt, top;
    xl       = {1'b0, x_q};
    xe       = xl + 11'(WIDTH);
    bot      = {1'b0, y_q} + 11'(HEIGHT);
    v        = (vy_q + 11'd1 > 11'(FALL_MAX)) ? 11'(FALL_MAX)
                                              : vy_q + 11'd1;
    nb       = bot + v;
    gnd      = (bot == 11'(FLOOR_Y));
    hit      = 1'b0;
    snap_top = '1;
    if (bot < 11'(FLOOR_Y) && 11'(FLOOR_Y) <= nb) begin
      hit      = 1'b1;
      snap_top = 11'(FLOOR_Y);
    end
    for (int i = 0; i < NUM_PLAT; i++) begin
      lft = {1'b0, PLAT_TABLE[30*i+20 +: 10]};
      rgt = {1'b0, PLAT_TABLE[30*i+10 +: 10]};
      top = {1'b0, PLAT_TABLE[30*i    +: 10]};
      if (xe >= lft && rgt >= xl) begin
        if (top == bot)
          gnd = 1'b1;
        if (bot < top && top <= nb && top < snap_top) begin
          hit      = 1'b1;
          snap_top = top;
        end
      end
    end
    snap_y = snap_top - 11'(HEIGHT);
    fall_y = {1'b0, y_q} + v;
  end

  // Next-state: spawn > kill > enabled frame tick; otherwise hold.
  always_comb begin
    st_d  = st_q;
    x_d   = x_q;
    y_d   = y_q;
    dir_d = dir_q;
    vy_d  = vy_q;
    cnt_d = cnt_q;
    if (spawn) begin
      st_d  = FALL;
      x_d   = 10'(START_X);
      y_d   = 10'(START_Y);
      dir_d = 1'(START_DIR);
      vy_d  = '0;
      cnt_d = '0;
    end else if (kill) begin
      if (st_q == WALK || st_q == FALL) begin
        st_d  = DYING;
        cnt_d = '0;
      end
    end else if (frame_tick && enable) begin
      unique case (st_q)
        WALK: begin
          if (!gnd) begin
            st_d = FALL;
            vy_d = '0;
          end else if (dir_q &&
                       xe + 11'(WALK_STEP) > 11'(SCREEN_W - 1)) begin
            dir_d = 1'b0;
          end else if (!dir_q && xl < 11'(WALK_STEP)) begin
            dir_d = 1'b1;
          end else if (dir_q) begin
            x_d = x_q + 10'(WALK_STEP);
          end else begin
            x_d = x_q - 10'(WALK_STEP);
          end
        end
        FALL: begin
          if (gnd) begin
            st_d = WALK;
            vy_d = '0;
          end else if (hit) begin
            y_d  = snap_y[9:0];
            vy_d = '0;
            st_d = WALK;
          end else begin
            y_d  = fall_y[9:0];
            vy_d = v;
          end
        end
        DYING: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(SQUASH_FRAMES - 1))
            st_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // Motion registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= FALL;
      x_q   <= 10'(START_X);
      y_q   <= 10'(START_Y);
      dir_q <= 1'(START_DIR);
      vy_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      x_q   <= x_d;
      y_q   <= y_d;
      dir_q <= dir_d;
      vy_q  <= vy_d;
      cnt_q <= cnt_d;
    end
  end

  assign goomba_x = x_q;
  assign goomba_y = y_q;
  assign dir      = dir_q;
  assign state    = st_q;
  assign grounded = gnd;
  assign alive    = (st_q == WALK) || (st_q == FALL);
  assign squash   = (st_q == DYING);

endmodule

// File: tb/tb_goomba_walker.sv
// tb_goomba_walker: directed scoreboard bench for goomba_walker.
// Three instances cover default spawn, right edge and ledge walk-off.
module tb_goomba_walker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [2:0] tk = '0;
  logic [2:0] kl = '0;
  logic [2:0] sp = '0;

  logic [9:0] ax, ay, bx, by, cx, cy;
  logic       adir, bdir, cdir;
  logic [1:0] ast, bst, cst;
  logic       agnd, bgnd, cgnd;
  logic       aal, bal, cal;
  logic       asq, bsq, csq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  goomba_walker u_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(tk[0]), .enable(enable),
    .kill(kl[0]), .spawn(sp[0]), .goomba_x(ax), .goomba_y(ay),
    .dir(adir), .state(ast), .grounded(agnd), .alive(aal),
    .squash(asq)
  );

  goomba_walker #(.START_X(610), .START_Y(413)) u_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(tk[1]), .enable(enable),
    .kill(kl[1]), .spawn(sp[1]), .goomba_x(bx), .goomba_y(by),
    .dir(bdir), .state(bst), .grounded(bgnd), .alive(bal),
    .squash(bsq)
  );

  goomba_walker #(.START_X(50), .START_Y(230), .START_DIR(1)) u_c (
    .clk(clk), .rst_n(rst_n), .frame_tick(tk[2]), .enable(enable),
    .kill(kl[2]), .spawn(sp[2]), .goomba_x(cx), .goomba_y(cy),
    .dir(cdir), .state(cst), .grounded(cgnd), .alive(cal),
    .squash(csq)
  );

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty obs=%0d exp=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s obs=%0d exp=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    tk = '0;
    kl = '0;
    sp = '0;
  endtask

  task automatic tick(input int w, input int n);
    for (int i = 0; i < n; i++) begin
      tk[w] = 1'b1;
      cyc();
    end
  endtask

  initial begin
    int ramp [4];
    int n;
    ramp = '{1, 3, 6, 10};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    push("rst_x", 300);   chk(32'(ax));
    push("rst_y", 0);     chk(32'(ay));
    push("rst_dir", 1);   chk(32'(adir));
    push("rst_st", 2);    chk(32'(ast));
    push("rst_alive", 1); chk(32'(aal));
    push("rst_squash", 0); chk(32'(asq));

    for (int i = 0; i < 4; i++) begin
      push($sformatf("ramp_y%0d", i + 1), 32'(ramp[i]));
      tick(0, 1);
      chk(32'(ay));
    end
    tick(0, 50);
    push("fall54_y", 210); chk(32'(ay));
    push("fall54_st", 2);  chk(32'(ast));
    push("fall55_y", 213);
    push("fall55_st", 1);
    push("fall55_gnd", 1);
    push("fall55_x", 300);
    tick(0, 1);
    chk(32'(ay));
    chk(32'(ast));
    chk(32'(agnd));
    chk(32'(ax));

    enable = 1'b0;
    push("dis_x", 300);
    push("dis_y", 213);
    push("dis_st", 1);
    push("dis_dir", 1);
    tick(0, 10);
    chk(32'(ax));
    chk(32'(ay));
    chk(32'(ast));
    chk(32'(adir));
    enable = 1'b1;

    push("walk_x", 301);
    tick(0, 1);
    chk(32'(ax));

    push("killtick_st", 3);
    push("killtick_x", 301);
    push("killtick_alive", 0);
    push("killtick_squash", 1);
    kl[0] = 1'b1;
    tk[0] = 1'b1;
    cyc();
    chk(32'(ast));
    chk(32'(ax));
    chk(32'(aal));
    chk(32'(asq));

    push("dying29_st", 3);
    tick(0, 29);
    chk(32'(ast));
    push("dying30_st", 0);
    push("idle_squash", 0);
    push("idle_alive", 0);
    tick(0, 1);
    chk(32'(ast));
    chk(32'(asq));
    chk(32'(aal));

    push("idle_hold_st", 0);
    push("idle_hold_x", 301);
    push("idle_hold_y", 213);
    tick(0, 5);
    kl[0] = 1'b1;
    cyc();
    chk(32'(ast));
    chk(32'(ax));
    chk(32'(ay));

    push("spawn_st", 2);
    push("spawn_x", 300);
    push("spawn_y", 0);
    sp[0] = 1'b1;
    cyc();
    chk(32'(ast));
    chk(32'(ax));
    chk(32'(ay));

    tick(0, 3);
    push("spk_st", 2);
    push("spk_y", 0);
    push("spk_alive", 1);
    sp[0] = 1'b1;
    kl[0] = 1'b1;
    cyc();
    chk(32'(ast));
    chk(32'(ay));
    chk(32'(aal));

    push("b_rst_gnd", 1); chk(32'(bgnd));
    push("b_t1_st", 1);
    tick(1, 1);
    chk(32'(bst));
    push("b_t2_x", 611); tick(1, 1); chk(32'(bx));
    push("b_t3_x", 612); tick(1, 1); chk(32'(bx));
    push("b_t4_x", 613); tick(1, 1); chk(32'(bx));
    push("b_t5_dir", 0);
    push("b_t5_x", 613);
    tick(1, 1);
    chk(32'(bdir));
    chk(32'(bx));
    push("b_t6_x", 612); tick(1, 1); chk(32'(bx));

    push("c_t1_st", 1);
    tick(2, 1);
    chk(32'(cst));
    push("c_x79", 79);
    push("c_gnd79", 1);
    tick(2, 29);
    chk(32'(cx));
    chk(32'(cgnd));
    push("c_x80", 80);
    push("c_gnd80", 0);
    push("c_st80", 1);
    tick(2, 1);
    chk(32'(cx));
    chk(32'(cgnd));
    chk(32'(cst));
    push("c_fall_st", 2);
    tick(2, 1);
    chk(32'(cst));
    push("c_fall_ticks", 23);
    n = 0;
    while (cst != 2'd1 && n < 100) begin
      tick(2, 1);
      n++;
    end
    chk(32'(n));
    push("c_land_y", 316);
    push("c_land_x", 80);
    push("c_land_gnd", 1);
    chk(32'(cy));
    chk(32'(cx));
    chk(32'(cgnd));

    kl[0] = 1'b1;
    cyc();
    tick(0, 3);
    push("predie_st", 3);
    chk(32'(ast));
    push("rstd_st", 2);
    push("rstd_x", 300);
    push("rstd_y", 0);
    push("rstd_squash", 0);
    push("rstd_alive", 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk(32'(ast));
    chk(32'(ax));
    chk(32'(ay));
    chk(32'(asq));
    chk(32'(aal));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
